hamming_scrub_ctrl: RTL and testbench

//  Memory scrubber for Hamming(7,4) protected storage. On start it walks every

---
 rtl/hamming_pkg.sv | 25 ++
 rtl/hamming_syndrome.sv | 28 ++
 rtl/hamming_scrub_ctrl.sv | 100 ++++++++++
 tb/tb_hamming_scrub_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(7,4) scrubber: controller states and
// codeword bit positions.
package hamming_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      CHK,
      WB,
      NXT,
      DONE
   } state_t;

   localparam int CW_W = 7;

   // Codeword layout {d3,d2,d1,p4,d0,p2,p1}
   localparam int P1 = 0;
   localparam int P2 = 1;
   localparam int D0 = 2;
   localparam int P4 = 3;
   localparam int D1 = 4;
   localparam int D2 = 5;
   localparam int D3 = 6;

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming(7,4) decoder: syndrome, single-bit corrected word and
// an error flag. A double-bit error aliases to a wrong single-bit fix.
module hamming_syndrome
   import hamming_pkg::*;
(
   input  logic [CW_W-1:0] codeword,
   output logic [2:0]      syndrome,
   output logic [CW_W-1:0] corrected,
   output logic            is_error
);

   logic c1;
   logic c2;
   logic c3;

   assign c1 = codeword[P1] ^ codeword[D0] ^ codeword[D1] ^ codeword[D3];
   assign c2 = codeword[P2] ^ codeword[D0] ^ codeword[D2] ^ codeword[D3];
   assign c3 = codeword[P4] ^ codeword[D1] ^ codeword[D2] ^ codeword[D3];

   assign syndrome = {c3, c2, c1};
   assign is_error = (syndrome != 3'd0);

   // Syndrome value k points at codeword bit k-1
   for (genvar gi = 0; gi < CW_W; gi++) begin : g_fix
      assign corrected[gi] = codeword[gi] ^ (syndrome == 3'(gi + 1));
   end

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// Scrub controller: walks addresses 0..DEPTH-1, decodes each word and writes
// back single-bit-corrected codewords, counting corrections.
module hamming_scrub_ctrl
   import hamming_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [CW_W-1:0]   mem_rdata,
   output logic              mem_wr_en,
   output logic [CW_W-1:0]   mem_wdata,
   output logic [CNT_W-1:0]  err_count,
   output logic [ADDR_W-1:0] last_err_addr
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   state_t              state_reg;
   state_t              state_next;
   logic [ADDR_W-1:0]   addr_reg;
   logic [CW_W-1:0]     wdata_reg;
   logic [CNT_W-1:0]    err_cnt_reg;
   logic [ADDR_W-1:0]   last_err_reg;

   logic [2:0]          syn;
   logic [CW_W-1:0]     corr;
   logic                is_err;

   hamming_syndrome u_syndrome (
      .codeword  (mem_rdata),
      .syndrome  (syn),
      .corrected (corr),
      .is_error  (is_err)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = RD;
         RD:      state_next = CHK;
         CHK:     state_next = (syn != 3'd0) ? WB : NXT;
         WB:      state_next = NXT;
         NXT:     state_next = (addr_reg == LAST_ADDR) ? DONE : RD;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         err_cnt_reg  <= '0;
         last_err_reg <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  addr_reg     <= '0;
                  err_cnt_reg  <= '0;
                  last_err_reg <= '0;
               end
            end
            CHK: begin
               if (is_err) wdata_reg <= corr;
            end
            WB: begin
               if (err_cnt_reg != CNT_MAX) err_cnt_reg <= err_cnt_reg + 1'b1;
               last_err_reg <= addr_reg;
            end
            NXT: begin
               if (addr_reg != LAST_ADDR) addr_reg <= addr_reg + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Moore strobes, so an asynchronous reset removes them immediately
   assign busy          = (state_reg != IDLE);
   assign done          = (state_reg == DONE);
   assign mem_rd_en     = (state_reg == RD);
   assign mem_wr_en     = (state_reg == WB);
   assign mem_addr      = addr_reg;
   assign mem_wdata     = wdata_reg;
   assign err_count     = err_cnt_reg;
   assign last_err_addr = last_err_reg;

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Directed bench for hamming_scrub_ctrl: two instances (CNT_W=8 and CNT_W=1)
// each backed by a 16x7 memory model with one-cycle read latency.
module tb_hamming_scrub_ctrl;

   logic       clk;
   logic       rst;

   logic       start;
   logic       busy;
   logic       done;
   logic [3:0] mem_addr;
   logic       mem_rd_en;
   logic [6:0] mem_rdata;
   logic       mem_wr_en;
   logic [6:0] mem_wdata;
   logic [7:0] err_count;
   logic [3:0] last_err_addr;

   logic       start_b;
   logic       busy_b;
   logic       done_b;
   logic [3:0] mem_addr_b;
   logic       mem_rd_en_b;
   logic [6:0] mem_rdata_b;
   logic       mem_wr_en_b;
   logic [6:0] mem_wdata_b;
   logic [0:0] err_count_b;
   logic [3:0] last_err_addr_b;

   logic [6:0] mem_a [16];
   logic [6:0] mem_b [16];
   logic       ld_en_a;
   logic       ld_en_b;
   logic [3:0] ld_addr;
   logic [6:0] ld_data;

   int         n_vec;
   int         n_err;
   logic [3:0] last_waddr;
   logic [6:0] last_wdata;

   hamming_scrub_ctrl #(.ADDR_W(4), .DEPTH(16), .CNT_W(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .mem_addr      (mem_addr),
      .mem_rd_en     (mem_rd_en),
      .mem_rdata     (mem_rdata),
      .mem_wr_en     (mem_wr_en),
      .mem_wdata     (mem_wdata),
      .err_count     (err_count),
      .last_err_addr (last_err_addr)
   );

   hamming_scrub_ctrl #(.ADDR_W(4), .DEPTH(16), .CNT_W(1)) dut_b (
      .clk           (clk),
      .rst           (rst),
      .start         (start_b),
      .busy          (busy_b),
      .done          (done_b),
      .mem_addr      (mem_addr_b),
      .mem_rd_en     (mem_rd_en_b),
      .mem_rdata     (mem_rdata_b),
      .mem_wr_en     (mem_wr_en_b),
      .mem_wdata     (mem_wdata_b),
      .err_count     (err_count_b),
      .last_err_addr (last_err_addr_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= mem_a[mem_addr];
      if (mem_wr_en) mem_a[mem_addr] <= mem_wdata;
      else if (ld_en_a) mem_a[ld_addr] <= ld_data;
      if (mem_rd_en_b) mem_rdata_b <= mem_b[mem_addr_b];
      if (mem_wr_en_b) mem_b[mem_addr_b] <= mem_wdata_b;
      else if (ld_en_b) mem_b[ld_addr] <= ld_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input bit sel_b, input logic [3:0] a, input logic [6:0] d);
      ld_addr = a;
      ld_data = d;
      if (sel_b) ld_en_b = 1'b1;
      else       ld_en_a = 1'b1;
      @(negedge clk);
      ld_en_a = 1'b0;
      ld_en_b = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge of the DONE cycle.
   // lat = cycles from RD of address 0 to DONE, -1 on timeout.
   task automatic run_pass(input bit hold, output int lat, output int nwr, output int rd0);
      lat   = -1;
      nwr   = 0;
      rd0   = -1;
      start = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!hold) start = 1'b0;
         if (mem_rd_en && mem_addr == 4'd0 && rd0 < 0) rd0 = i;
         if (mem_wr_en) begin
            nwr++;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
         end
         if (done) begin
            lat = i - rd0;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      int nwr;
      int rd0;
      bit found;

      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      start = 1'b0;
      start_b = 1'b0;
      ld_en_a = 1'b0;
      ld_en_b = 1'b0;
      ld_addr = '0;
      ld_data = '0;
      last_waddr = '0;
      last_wdata = '0;
      repeat (3) @(negedge clk);

      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_rd_en", mem_rd_en, 1'b0);
      chk("rst_wr_en", mem_wr_en, 1'b0);
      chk("rst_outs", {mem_addr, mem_wdata, err_count, last_err_addr}, 23'd0);
      rst = 1'b0;
      @(negedge clk);

      // Even addresses hold 7'h00, odd 7'h7F; both memories
      for (int i = 0; i < 16; i++) begin
         load(1'b0, 4'(i), (i % 2 == 0) ? 7'h00 : 7'h7F);
         load(1'b1, 4'(i), (i % 2 == 0) ? 7'h00 : 7'h7F);
      end

      // 1: clean pass
      run_pass(1'b0, lat, nwr, rd0);
      chk("t1_latency", lat, 48);
      chk("t1_writes", nwr, 0);
      chk("t1_err_count", err_count, 8'd0);
      chk("t1_busy_in_done", busy, 1'b1);
      @(negedge clk);
      chk("t1_done_pulse", {busy, done}, 2'b00);

      // 2: single fault at address 5, bit 4
      load(1'b0, 4'd5, 7'h7F ^ 7'h10);
      run_pass(1'b0, lat, nwr, rd0);
      chk("t2_latency", lat, 49);
      chk("t2_writes", nwr, 1);
      chk("t2_waddr", last_waddr, 4'd5);
      chk("t2_wdata", last_wdata, 7'h7F);
      chk("t2_err_count", err_count, 8'd1);
      chk("t2_last_err_addr", last_err_addr, 4'd5);
      @(negedge clk);
      chk("t2_mem5_fixed", mem_a[5], 7'h7F);
      chk("t2_hold_idle", {err_count, last_err_addr}, {8'd1, 4'd5});

      // 3: faults at address 0 bit 0 and address 15 bit 6
      load(1'b0, 4'd0, 7'h01);
      load(1'b0, 4'd15, 7'h3F);
      run_pass(1'b0, lat, nwr, rd0);
      chk("t3_latency", lat, 50);
      chk("t3_writes", nwr, 2);
      chk("t3_wdata", last_wdata, 7'h7F);
      chk("t3_err_count", err_count, 8'd2);
      chk("t3_last_err_addr", last_err_addr, 4'd15);
      @(negedge clk);
      chk("t3_mem0_fixed", mem_a[0], 7'h00);
      chk("t3_mem15_fixed", mem_a[15], 7'h7F);

      // 4: CNT_W=1 saturates with three faulty words
      load(1'b1, 4'd2, 7'h04);
      load(1'b1, 4'd9, 7'h77);
      load(1'b1, 4'd13, 7'h02);
      nwr = 0;
      found = 1'b0;
      start_b = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         start_b = 1'b0;
         if (mem_wr_en_b) nwr++;
         if (done_b) begin
            found = 1'b1;
            break;
         end
      end
      chk("t4_done_seen", found, 1'b1);
      chk("t4_writes", nwr, 3);
      chk("t4_err_count_sat", err_count_b, 1'b1);
      chk("t4_last_err_addr", last_err_addr_b, 4'd13);
      @(negedge clk);
      chk("t4_mem2_fixed", mem_b[2], 7'h00);
      chk("t4_mem9_fixed", mem_b[9], 7'h7F);

      // 5: reset during the write-back of address 7
      load(1'b0, 4'd7, 7'h7E);
      found = 1'b0;
      start = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (mem_wr_en && mem_addr == 4'd7) begin
            found = 1'b1;
            break;
         end
      end
      chk("t5_wb_seen", found, 1'b1);
      rst = 1'b1;
      #1;
      chk("t5_wr_en_drop", mem_wr_en, 1'b0);
      chk("t5_busy_drop", busy, 1'b0);
      chk("t5_outs_zero", {mem_rd_en, done, mem_addr, mem_wdata, err_count, last_err_addr}, 25'd0);
      @(negedge clk);
      rst = 1'b0;
      chk("t5_mem7_unwritten", mem_a[7], 7'h7E);
      @(negedge clk);
      run_pass(1'b0, lat, nwr, rd0);
      chk("t5_restart_addr0", rd0, 0);
      chk("t5_latency", lat, 49);
      chk("t5_err_count", err_count, 8'd1);
      chk("t5_last_err_addr", last_err_addr, 4'd7);

      // 6: start held through the pass
      run_pass(1'b1, lat, nwr, rd0);
      chk("t6_latency", lat, 48);
      @(negedge clk);
      chk("t6_idle_after_done", {busy, done, mem_rd_en}, 3'b000);
      @(negedge clk);
      chk("t6_new_pass", {busy, mem_rd_en, mem_addr}, {2'b11, 4'd0});
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) begin
            found = 1'b1;
            break;
         end
      end
      chk("t6_second_done", found, 1'b1);
      @(negedge clk);
      chk("t6_stays_idle", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
